// File: rtl/bip_uart_frame_sequencer.sv
// Frames a halted BIP's ACC and PC into a six-byte uart_tx packet:
// header, ACC lo/hi, PC lo/hi, XOR checksum of the four data bytes.
`timescale 1ns/1ps
module bip_uart_frame_sequencer #(
  parameter int          NBITS_D = 16,
  parameter int          NBITS_O = 11,
  parameter int          DBIT    = 8,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int          TIMEOUT = 2**20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic [NBITS_D-1:0] i_acc,
  input  logic [NBITS_O-1:0] i_pc,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [DBIT-1:0]    o_tx_data,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_error
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic              halt_q;
  logic [15:0]       acc_r, pc_r;
  logic [2:0]        idx_reg, idx_next;
  logic [WD_W-1:0]   wd_reg, wd_next;
  logic [DBIT-1:0]   data_reg, data_next;
  logic              error_reg, error_next;
  logic              capture;
  logic              trigger;

  assign trigger = i_halt & ~halt_q;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [15:0] acc,
                                            input logic [15:0] pc);
    logic [7:0] fb;
    case (idx)
      3'd0:    fb = HEADER;
      3'd1:    fb = acc[7:0];
      3'd2:    fb = acc[15:8];
      3'd3:    fb = pc[7:0];
      3'd4:    fb = pc[15:8];
      default: fb = acc[7:0] ^ acc[15:8] ^ pc[7:0] ^ pc[15:8];
    endcase
    return fb;
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= IDLE;
      halt_q    <= 1'b0;
      acc_r     <= '0;
      pc_r      <= '0;
      idx_reg   <= '0;
      wd_reg    <= '0;
      data_reg  <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      halt_q    <= i_halt;
      idx_reg   <= idx_next;
      wd_reg    <= wd_next;
      data_reg  <= data_next;
      error_reg <= error_next;
      if (capture) begin
        acc_r <= 16'(i_acc);
        pc_r  <= 16'(i_pc);
      end
    end
  end

  // The byte register is loaded on entry to SEND so the data is already
  // valid in the cycle o_tx_start is high, and holds through WAIT.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wd_next    = wd_reg;
    data_next  = data_reg;
    error_next = error_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (trigger) begin
          capture    = 1'b1;
          idx_next   = 3'd0;
          data_next  = DBIT'(HEADER);
          state_next = SEND;
        end
      end
      SEND: begin
        wd_next    = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (i_tx_done) begin
          if (idx_reg == 3'd5) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 3'd1;
            data_next  = DBIT'(frame_byte(idx_reg + 3'd1, acc_r, pc_r));
            state_next = SEND;
          end
        end else if (wd_reg == WD_LAST) begin
          error_next = 1'b1;
          state_next = IDLE;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign o_tx_start   = (state_reg == SEND);
  assign o_busy       = (state_reg != IDLE);
  assign o_frame_done = (state_reg == DONE);
  assign o_tx_data    = data_reg;
  assign o_error      = error_reg;

endmodule

// File: tb/tb_bip_uart_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected frame bytes, a monitor checks
// every start/byte/done event and a uart_tx model answers each start.
`timescale 1ns/1ps
module tb_bip_uart_frame_sequencer;

  localparam int TO = 64;

  logic        clk;
  logic        rst;
  logic        halt;
  logic [15:0] acc;
  logic [10:0] pc;
  logic        u_done, s_done, tx_done;
  logic        tx_start, busy, fdone, err;
  logic [7:0]  tx_data;

  assign tx_done = u_done | s_done;

  bip_uart_frame_sequencer #(
    .NBITS_D(16), .NBITS_O(11), .DBIT(8), .HEADER(8'hA5), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_halt(halt), .i_acc(acc), .i_pc(pc),
    .i_tx_done(tx_done), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_busy(busy), .o_frame_done(fdone), .o_error(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int n_starts = 0;
  int n_fdone = 0;
  int last_start_cyc = 0;
  bit abort_ok = 1'b0;
  int reply_delay = 20;
  int withhold_at = -1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // Reference frame: little-endian halves of the zero-extended values,
  // closed by the XOR of the four data bytes.
  task automatic push_frame(input logic [15:0] a, input logic [15:0] p,
                            input int nbytes);
    logic [7:0] b[6];
    b[0] = 8'hA5;
    b[1] = 8'(a % 256);
    b[2] = 8'(a / 256);
    b[3] = 8'(p % 256);
    b[4] = 8'(p / 256);
    b[5] = b[1] ^ b[2] ^ b[3] ^ b[4];
    for (int i = 0; i < nbytes; i++) exp_q.push_back(b[i]);
  endtask

  task automatic push_const(input logic [47:0] bytes);
    for (int i = 5; i >= 0; i--) exp_q.push_back(bytes[i*8 +: 8]);
  endtask

  task automatic wait_fdone(input int target, input int budget);
    int k;
    k = 0;
    while (n_fdone < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (n_fdone < target) begin
      fails++;
      $display("FAIL wait_frame_done: got %0d frames, required %0d", n_fdone, target);
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k;
    k = 0;
    while (n_starts < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (n_starts < target) begin
      fails++;
      $display("FAIL wait_starts: got %0d starts, required %0d", n_starts, target);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_start"}, tx_start, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_frame_done"}, fdone, 1'b0);
    check({tag, "_error"}, err, 1'b0);
  endtask

  // uart_tx model: done pulse reply_delay cycles after each start
  initial begin
    int u_starts;
    u_starts = 0;
    u_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        u_starts++;
        if (u_starts != withhold_at) begin
          repeat (reply_delay) @(posedge clk);
          #1 u_done = 1'b1;
          @(posedge clk);
          #1 u_done = 1'b0;
        end
      end
    end
  end

  // Monitor: event-level model of when starts and frame-done must appear
  bit m_active, m_wait, exp_start, exp_fdone, halt_prev, fd_now;
  int m_nbytes;
  logic [7:0] held, e;
  initial begin
    m_active = 0; m_wait = 0; exp_start = 0; exp_fdone = 0; halt_prev = 0;
    m_nbytes = 0; held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 0; m_wait = 0; exp_start = 0; exp_fdone = 0; halt_prev = 0;
        exp_q.delete();
      end else begin
        if (abort_ok && m_active && !busy) begin
          m_active = 0;
          m_wait   = 0;
          abort_ok = 0;
        end
        if (exp_start || tx_start) check("start_timing", tx_start, exp_start);
        if (tx_start) begin
          n_starts++;
          last_start_cyc = cyc;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_start: data %0h, required no start", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", tx_data, e);
          end
          $display("[TB] cycle %0d start byte=%02h", cyc, tx_data);
          held   = tx_data;
          m_wait = 1;
        end else if (m_wait) begin
          check("data_stable", tx_data, held);
        end
        if (exp_fdone || fdone) check("frame_done", fdone, exp_fdone);
        if (fdone) n_fdone++;
        fd_now    = exp_fdone;
        exp_start = 0;
        exp_fdone = 0;
        if (m_wait && !tx_start && tx_done) begin
          m_wait = 0;
          if (m_nbytes == 6) exp_fdone = 1;
          else begin
            exp_start = 1;
            m_nbytes++;
          end
        end
        if (halt && !halt_prev && !m_active) begin
          exp_start = 1;
          m_active  = 1;
          m_nbytes  = 1;
        end
        if (fd_now) m_active = 0;
        halt_prev = halt;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, fbase, t0, k;
    logic [15:0] a, p;
    rst = 1'b1; halt = 1'b0; acc = '0; pc = '0; s_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Basic frame, halt then held high: no retrigger
    #1 acc = 16'h1234; pc = 11'h07F;
    push_const(48'hA5_34_12_7F_00_59);
    base = n_starts; fbase = n_fdone;
    halt = 1'b1;
    wait_fdone(fbase + 1, 1000);
    check("basic_starts", n_starts - base, 6);
    @(negedge clk);
    check("basic_busy_after", busy, 1'b0);
    repeat (100) @(negedge clk);
    check("no_retrigger", n_starts - base, 6);

    // Max values; ACC cleared and halt re-pulsed mid-frame
    @(posedge clk); #1 halt = 1'b0; acc = 16'hFFFF; pc = 11'h7FF;
    push_const(48'hA5_FF_FF_FF_07_F8);
    base = n_starts; fbase = n_fdone;
    @(posedge clk); #1 halt = 1'b1;
    wait_starts(base + 3, 500);
    @(posedge clk); #1 acc = 16'h0000; halt = 1'b0;
    @(posedge clk); #1 halt = 1'b1;
    wait_fdone(fbase + 1, 1000);
    check("max_starts", n_starts - base, 6);

    // Random frames with random reply latency and mid-frame input changes
    for (int f = 0; f < 8; f++) begin
      @(posedge clk); #1 halt = 1'b0;
      a = 16'($urandom); p = 16'($urandom_range(0, 2047));
      reply_delay = $urandom_range(1, 25);
      acc = a; pc = p[10:0];
      push_frame(a, p, 6);
      base = n_starts; fbase = n_fdone;
      @(posedge clk); #1 halt = 1'b1;
      wait_starts(base + 1 + $urandom_range(0, 4), 1000);
      @(posedge clk); #1 acc = 16'($urandom); pc = 11'($urandom);
      wait_fdone(fbase + 1, 2000);
      check("rand_starts", n_starts - base, 6);
    end

    // Spurious done while idle
    @(posedge clk); #1 halt = 1'b0;
    repeat (3) @(posedge clk);
    #1 s_done = 1'b1;
    @(posedge clk); #1 s_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spurious_no_start", tx_start, 1'b0);
      check("spurious_idle", busy, 1'b0);
    end

    // Timeout: no done after the PC-low byte's start
    reply_delay = 10;
    a = 16'($urandom); p = 16'($urandom_range(0, 2047));
    acc = a; pc = p[10:0];
    base = n_starts;
    withhold_at = base + 4;
    push_frame(a, p, 4);
    abort_ok = 1'b1;
    @(posedge clk); #1 halt = 1'b1;
    wait_starts(base + 4, 500);
    t0 = last_start_cyc;
    k = 0;
    while (!err && k < 200) begin
      @(negedge clk);
      k++;
    end
    // SEND cycle, then 64 WAIT cycles, then the error register shows it
    check("timeout_delay", cyc - t0, 65);
    check("timeout_busy", busy, 1'b0);
    check("timeout_error", err, 1'b1);
    withhold_at = -1;
    @(posedge clk); #1 halt = 1'b0;
    a = 16'($urandom); p = 16'($urandom_range(0, 2047));
    acc = a; pc = p[10:0];
    push_frame(a, p, 6);
    base = n_starts; fbase = n_fdone;
    @(posedge clk); #1 halt = 1'b1;
    wait_fdone(fbase + 1, 1000);
    check("after_timeout_starts", n_starts - base, 6);
    check("error_sticky", err, 1'b1);

    // Async reset mid-frame, released with halt still high
    reply_delay = 20;
    @(posedge clk); #1 halt = 1'b0;
    a = 16'($urandom); p = 16'($urandom_range(0, 2047));
    acc = a; pc = p[10:0];
    push_frame(a, p, 6);
    base = n_starts;
    @(posedge clk); #1 halt = 1'b1;
    wait_starts(base + 3, 500);
    @(posedge clk); #3 rst = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (30) @(posedge clk);
    #1;
    a = 16'($urandom); p = 16'($urandom_range(0, 2047));
    acc = a; pc = p[10:0];
    push_frame(a, p, 6);
    base = n_starts; fbase = n_fdone;
    rst = 1'b0;
    wait_fdone(fbase + 1, 1000);
    check("post_reset_starts", n_starts - base, 6);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
